control_sequencer: RTL

Parametrised instruction-phase sequencer for the Luna CPU. It replaces the fixed two-phase decode/writeback clock generator with single-clock, one-hot phase enables, and it supports a configurable phase count. It stretches a designated memory phase on `mem_ready` and provides run/halt and single-step control, plus instruction and wait-cycle counters. It sits between the top-level clock/reset and the control unit, register file and PC, which qualify their register enables with `phase_oh[k] & adv`.

---
 rtl/control_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Instruction-phase sequencer for the Luna CPU. Produces single-clock, one-hot
// phase enables for a configurable number of phases per instruction. A
// designated memory phase is stretched while mem_ready is low. Run/halt and
// single-step control are provided, along with an instruction counter and a
// wait-cycle counter.
//
// Downstream blocks qualify their register enables with phase_oh[k] & adv.
//
// Parameters:
//   NUM_PHASES  phases per instruction (2..16); phase 0 = fetch, last = writeback
//   IDX_W       width of phase_idx, >= ceil(log2(NUM_PHASES))
//   WAIT_PHASE  index of the phase held while mem_ready is low
//   CNT_W       width of instr_count / wait_cycles
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   run_en       level, 1 = free-run instructions back to back
//   step         single-step request, acted on at its rising edge
//   mem_ready    memory handshake, only sampled in WAIT_PHASE
//   phase_idx    current phase number (0 when halted)
//   phase_oh     one-hot current phase (all-zero when halted)
//   adv          current phase ends at the next rising edge (combinational)
//   instr_done   final phase advancing this cycle (combinational)
//   halted       sequencer is halted
//   instr_count  completed instructions, wraps
//   wait_cycles  stalled cycles, saturates at all-ones
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int IDX_W      = 2,
    parameter int WAIT_PHASE = 0,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_en,
    input  logic                  step,
    input  logic                  mem_ready,
    output logic [IDX_W-1:0]      phase_idx,
    output logic [NUM_PHASES-1:0] phase_oh,
    output logic                  adv,
    output logic                  instr_done,
    output logic                  halted,
    output logic [CNT_W-1:0]      instr_count,
    output logic [CNT_W-1:0]      wait_cycles
);

    typedef enum logic [0:0] {
        ST_HALTED = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);
    localparam logic [IDX_W-1:0] WAIT_IDX = IDX_W'(WAIT_PHASE);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // One-hot decode of a phase index.
    function automatic logic [NUM_PHASES-1:0] phase_decode(input logic [IDX_W-1:0] idx);
        logic [NUM_PHASES-1:0] one_s;
        one_s = {{(NUM_PHASES-1){1'b0}}, 1'b1};
        return one_s << idx;
    endfunction

    state_t                  state_r;
    state_t                  next_state_s;
    logic [IDX_W-1:0]        phase_r;
    logic [IDX_W-1:0]        next_phase_s;
    logic [NUM_PHASES-1:0]   phase_oh_r;
    logic                    halted_r;
    logic                    step_q_r;
    logic                    step_rise_s;
    logic                    adv_s;
    logic                    instr_done_s;
    logic [CNT_W-1:0]        instr_count_r;
    logic [CNT_W-1:0]        wait_cycles_r;

    assign step_rise_s = step & ~step_q_r;

    // Phase-advance and instruction-complete strobes from state and mem_ready.
    always_comb begin
        adv_s        = 1'b0;
        instr_done_s = 1'b0;
        if (state_r == ST_RUN) begin
            // Only the wait phase listens to mem_ready; every other phase is one cycle.
            adv_s        = (phase_r != WAIT_IDX) | mem_ready;
            instr_done_s = adv_s & (phase_r == LAST_IDX);
        end else begin
            adv_s        = 1'b0;
            instr_done_s = 1'b0;
        end
    end

    // Next-state / next-phase decode.
    always_comb begin
        next_state_s = state_r;
        next_phase_s = phase_r;
        case (state_r)
            ST_HALTED: begin
                if (run_en | step_rise_s) begin
                    next_state_s = ST_RUN;
                    next_phase_s = IDX_ZERO;
                end else begin
                    next_state_s = ST_HALTED;
                    next_phase_s = IDX_ZERO;
                end
            end
            ST_RUN: begin
                if (!adv_s) begin
                    next_state_s = ST_RUN;
                    next_phase_s = phase_r;
                end else if (phase_r != LAST_IDX) begin
                    next_state_s = ST_RUN;
                    next_phase_s = phase_r + IDX_ONE;
                end else if (run_en) begin
                    // Back-to-back instructions: no bubble between writeback and fetch.
                    next_state_s = ST_RUN;
                    next_phase_s = IDX_ZERO;
                end else begin
                    // run_en dropped: halt only once the instruction has completed.
                    next_state_s = ST_HALTED;
                    next_phase_s = IDX_ZERO;
                end
            end
            default: begin
                next_state_s = ST_HALTED;
                next_phase_s = IDX_ZERO;
            end
        endcase
    end

    // Sequencer FSM with registered phase, one-hot and halted outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_HALTED;
            phase_r    <= IDX_ZERO;
            phase_oh_r <= {NUM_PHASES{1'b0}};
            halted_r   <= 1'b1;
        end else begin
            state_r    <= next_state_s;
            phase_r    <= next_phase_s;
            phase_oh_r <= (next_state_s == ST_RUN) ? phase_decode(next_phase_s)
                                                   : {NUM_PHASES{1'b0}};
            halted_r   <= (next_state_s == ST_HALTED);
        end
    end

    // Step edge detector register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q_r <= 1'b0;
        end else begin
            step_q_r <= step;
        end
    end

    // Instruction counter (wraps) and stall counter (saturates).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_count_r <= {CNT_W{1'b0}};
            wait_cycles_r <= {CNT_W{1'b0}};
        end else begin
            if (instr_done_s) begin
                instr_count_r <= instr_count_r + CNT_ONE;
            end
            if ((state_r == ST_RUN) && !adv_s && (wait_cycles_r != CNT_MAX)) begin
                wait_cycles_r <= wait_cycles_r + CNT_ONE;
            end
        end
    end

    assign phase_idx   = phase_r;
    assign phase_oh    = phase_oh_r;
    assign adv         = adv_s;
    assign instr_done  = instr_done_s;
    assign halted      = halted_r;
    assign instr_count = instr_count_r;
    assign wait_cycles = wait_cycles_r;

endmodule
